// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path.
//   NOTE_W  : MIDI note number width
//   state_e : voice allocator FSM encoding
//   ev_e    : latched event type
package synth_pkg;

  localparam int NOTE_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef enum logic {
    EV_ON  = 1'b0,
    EV_OFF = 1'b1
  } ev_e;

endpackage

// File: rtl/voice_slot.sv
// One voice's bookkeeping: note, gate and a saturating age counter.
//   clk, rst   : clock, async active-high reset
//   load       : assign load_note, open gate, clear age
//   rel        : close gate, keep note and age for the release phase
//   age_inc    : bump age by one if gated, saturating at VOICES-1
//   load_note  : note to assign on load
//   note/gate/age : current slot state (registered)
module voice_slot
  import synth_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int VW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              rel,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] load_note,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic [VW-1:0]     age
);

  localparam logic [VW-1:0] AGE_MAX = VW'(VOICES - 1);

  logic [NOTE_W-1:0] note_q, note_d;
  logic              gate_q, gate_d;
  logic [VW-1:0]     age_q, age_d;

  // Next-state for the slot; load wins over release over ageing.
  always_comb begin
    note_d = note_q;
    gate_d = gate_q;
    age_d  = age_q;
    if (load) begin
      note_d = load_note;
      gate_d = 1'b1;
      age_d  = {VW{1'b0}};
    end else if (rel) begin
      gate_d = 1'b0;
    end else if (age_inc && gate_q && (age_q != AGE_MAX)) begin
      age_d = age_q + VW'(1);
    end else begin
      age_d = age_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_q <= {NOTE_W{1'b0}};
      gate_q <= 1'b0;
      age_q  <= {VW{1'b0}};
    end else begin
      note_q <= note_d;
      gate_q <= gate_d;
      age_q  <= age_d;
    end
  end

  assign note = note_q;
  assign gate = gate_q;
  assign age  = age_q;

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator. Each accepted note_on/note_off is resolved by a
// one-voice-per-cycle scan followed by a commit cycle.
//   clk, rst      : clock, async active-high reset
//   note_on/off   : one-cycle event strobes (note_on wins if both high)
//   note          : note number qualified by either strobe
//   busy          : event in progress; strobes seen while high are dropped
//   voice_note    : per-voice note, voice i at [7i+6:7i]
//   voice_gate    : per-voice gate
//   voice_trig    : one-cycle pulse on the voice (re)assigned by note_on
//   steal         : one-cycle pulse with voice_trig when an active voice was stolen
module voice_alloc
  import synth_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int VW     = $clog2(VOICES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     note_on,
  input  logic                     note_off,
  input  logic [NOTE_W-1:0]        note,
  output logic                     busy,
  output logic [NOTE_W*VOICES-1:0] voice_note,
  output logic [VOICES-1:0]        voice_gate,
  output logic [VOICES-1:0]        voice_trig,
  output logic                     steal
);

  state_e            state_q, state_d;
  logic [VW-1:0]     idx_q, idx_d;
  ev_e               ev_q, ev_d;
  logic [NOTE_W-1:0] lnote_q, lnote_d;
  logic              match_ok_q, match_ok_d, free_ok_q, free_ok_d, old_ok_q, old_ok_d;
  logic [VW-1:0]     match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [VW-1:0]     old_idx_q, old_idx_d, old_age_q, old_age_d;
  logic [VOICES-1:0] trig_q, trig_d;
  logic              steal_q, steal_d;

  logic [NOTE_W-1:0] slot_note [VOICES];
  logic [VW-1:0]     slot_age  [VOICES];
  logic [VOICES-1:0] slot_gate;
  logic [VOICES-1:0] load_s, rel_s, age_inc_s;
  logic [VW-1:0]     target_s;

  // FSM next-state, scan trackers and commit controls.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ev_d        = ev_q;
    lnote_d     = lnote_q;
    match_ok_d  = match_ok_q;
    match_idx_d = match_idx_q;
    free_ok_d   = free_ok_q;
    free_idx_d  = free_idx_q;
    old_ok_d    = old_ok_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    trig_d      = {VOICES{1'b0}};
    steal_d     = 1'b0;
    load_s      = {VOICES{1'b0}};
    rel_s       = {VOICES{1'b0}};
    age_inc_s   = {VOICES{1'b0}};
    target_s    = {VW{1'b0}};
    case (state_q)
      IDLE: begin
        if (note_on || note_off) begin
          ev_d       = note_on ? EV_ON : EV_OFF;
          lnote_d    = note;
          match_ok_d = 1'b0;
          free_ok_d  = 1'b0;
          old_ok_d   = 1'b0;
          idx_d      = {VW{1'b0}};
          state_d    = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!match_ok_q && slot_gate[idx_q] && (slot_note[idx_q] == lnote_q)) begin
          match_ok_d  = 1'b1;
          match_idx_d = idx_q;
        end else begin
          match_ok_d = match_ok_q;
        end
        if (!free_ok_q && !slot_gate[idx_q]) begin
          free_ok_d  = 1'b1;
          free_idx_d = idx_q;
        end else begin
          free_ok_d = free_ok_q;
        end
        // Strict '>' keeps the lowest index on equal ages.
        if (slot_gate[idx_q] && (!old_ok_q || (slot_age[idx_q] > old_age_q))) begin
          old_ok_d  = 1'b1;
          old_idx_d = idx_q;
          old_age_d = slot_age[idx_q];
        end else begin
          old_ok_d = old_ok_q;
        end
        if (idx_q == VW'(VOICES - 1)) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + VW'(1);
        end
      end
      COMMIT: begin
        if (ev_q == EV_ON) begin
          if (match_ok_q) begin
            target_s = match_idx_q;
          end else if (free_ok_q) begin
            target_s = free_idx_q;
          end else begin
            target_s = old_idx_q;
          end
          steal_d = !match_ok_q && !free_ok_q;
          for (int i = 0; i < VOICES; i++) begin
            if (target_s == VW'(i)) begin
              load_s[i] = 1'b1;
              trig_d[i] = 1'b1;
            end else begin
              age_inc_s[i] = 1'b1;  // slot ignores this when not gated
            end
          end
        end else begin
          for (int i = 0; i < VOICES; i++) begin
            if (match_ok_q && (match_idx_q == VW'(i))) begin
              rel_s[i] = 1'b1;
            end else begin
              rel_s[i] = 1'b0;
            end
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, scan trackers and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= {VW{1'b0}};
      ev_q        <= EV_ON;
      lnote_q     <= {NOTE_W{1'b0}};
      match_ok_q  <= 1'b0;
      match_idx_q <= {VW{1'b0}};
      free_ok_q   <= 1'b0;
      free_idx_q  <= {VW{1'b0}};
      old_ok_q    <= 1'b0;
      old_idx_q   <= {VW{1'b0}};
      old_age_q   <= {VW{1'b0}};
      trig_q      <= {VOICES{1'b0}};
      steal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ev_q        <= ev_d;
      lnote_q     <= lnote_d;
      match_ok_q  <= match_ok_d;
      match_idx_q <= match_idx_d;
      free_ok_q   <= free_ok_d;
      free_idx_q  <= free_idx_d;
      old_ok_q    <= old_ok_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      trig_q      <= trig_d;
      steal_q     <= steal_d;
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_slot
    voice_slot #(.VOICES(VOICES), .VW(VW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load_s[g]),
      .rel       (rel_s[g]),
      .age_inc   (age_inc_s[g]),
      .load_note (lnote_q),
      .note      (slot_note[g]),
      .gate      (slot_gate[g]),
      .age       (slot_age[g])
    );
    assign voice_note[NOTE_W*g +: NOTE_W] = slot_note[g];
  end

  assign busy       = (state_q != IDLE);
  assign voice_gate = slot_gate;
  assign voice_trig = trig_q;
  assign steal      = steal_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Scoreboard bench for voice_alloc (VOICES=4). Stimulus pushes the expected
// post-commit outputs; a monitor pops them when busy falls.
module tb_voice_alloc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        note_on = 1'b0;
  logic        note_off = 1'b0;
  logic [6:0]  note = 7'd0;
  logic        busy;
  logic [27:0] voice_note;
  logic [3:0]  voice_gate;
  logic [3:0]  voice_trig;
  logic        steal;

  typedef struct packed {
    logic [3:0]  gate;
    logic [27:0] notes;
    logic [3:0]  trig;
    logic        stl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  voice_alloc #(.VOICES(4), .VW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .note_on    (note_on),
    .note_off   (note_off),
    .note       (note),
    .busy       (busy),
    .voice_note (voice_note),
    .voice_gate (voice_gate),
    .voice_trig (voice_trig),
    .steal      (steal)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [27:0] pk(input logic [6:0] n3, input logic [6:0] n2,
                                     input logic [6:0] n1, input logic [6:0] n0);
    return {n3, n2, n1, n0};
  endfunction

  task automatic expect_out(input logic [3:0] g, input logic [27:0] n,
                            input logic [3:0] t, input logic s);
    exp_t e;
    e.gate  = g;
    e.notes = n;
    e.trig  = t;
    e.stl   = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int expect_len);
    int cnt;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk(name, cnt, expect_len);
  endtask

  task automatic send(input logic on, input logic off, input logic [6:0] n,
                      input logic [3:0] g, input logic [27:0] en,
                      input logic [3:0] t, input logic s);
    expect_out(g, en, t, s);
    @(negedge clk);
    note_on  = on;
    note_off = off;
    note     = n;
    @(negedge clk);
    note_on  = 1'b0;
    note_off = 1'b0;
    wait_idle("busy_len", 5);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: result is due on the cycle busy drops; pulses clear one cycle later.
  initial begin
    logic prev_busy;
    logic chk_clear;
    exp_t e;
    prev_busy = 1'b0;
    chk_clear = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        chk_clear = 1'b0;
      end else begin
        if (chk_clear) begin
          chk("trig_clear", {28'd0, voice_trig}, 32'd0);
          chk("steal_clear", {31'd0, steal}, 32'd0);
          chk_clear = 1'b0;
        end
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("gate", {28'd0, voice_gate}, {28'd0, e.gate});
            chk("notes", {4'd0, voice_note}, {4'd0, e.notes});
            chk("trig", {28'd0, voice_trig}, {28'd0, e.trig});
            chk("steal", {31'd0, steal}, {31'd0, e.stl});
          end
          chk_clear = 1'b1;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    do_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gate", {28'd0, voice_gate}, 32'd0);
    chk("rst_note", {4'd0, voice_note}, 32'd0);
    chk("rst_trig", {28'd0, voice_trig}, 32'd0);
    chk("rst_steal", {31'd0, steal}, 32'd0);

    // Fill all four voices, then steal the two oldest in turn.
    send(1'b1, 1'b0, 7'd60, 4'b0001, pk(7'd0, 7'd0, 7'd0, 7'd60), 4'b0001, 1'b0);
    send(1'b1, 1'b0, 7'd64, 4'b0011, pk(7'd0, 7'd0, 7'd64, 7'd60), 4'b0010, 1'b0);
    send(1'b1, 1'b0, 7'd67, 4'b0111, pk(7'd0, 7'd67, 7'd64, 7'd60), 4'b0100, 1'b0);
    send(1'b1, 1'b0, 7'd72, 4'b1111, pk(7'd72, 7'd67, 7'd64, 7'd60), 4'b1000, 1'b0);
    send(1'b1, 1'b0, 7'd76, 4'b1111, pk(7'd72, 7'd67, 7'd64, 7'd76), 4'b0001, 1'b1);
    send(1'b1, 1'b0, 7'd80, 4'b1111, pk(7'd72, 7'd67, 7'd80, 7'd76), 4'b0010, 1'b1);

    // Release keeps the note; a freed voice is reused first.
    do_reset();
    send(1'b1, 1'b0, 7'd60, 4'b0001, pk(7'd0, 7'd0, 7'd0, 7'd60), 4'b0001, 1'b0);
    send(1'b1, 1'b0, 7'd64, 4'b0011, pk(7'd0, 7'd0, 7'd64, 7'd60), 4'b0010, 1'b0);
    send(1'b0, 1'b1, 7'd60, 4'b0010, pk(7'd0, 7'd0, 7'd64, 7'd60), 4'b0000, 1'b0);
    send(1'b1, 1'b0, 7'd62, 4'b0011, pk(7'd0, 7'd0, 7'd64, 7'd62), 4'b0001, 1'b0);

    // Retrigger of a held note and note_off of an unheld note.
    do_reset();
    send(1'b1, 1'b0, 7'd60, 4'b0001, pk(7'd0, 7'd0, 7'd0, 7'd60), 4'b0001, 1'b0);
    send(1'b1, 1'b0, 7'd60, 4'b0001, pk(7'd0, 7'd0, 7'd0, 7'd60), 4'b0001, 1'b0);
    send(1'b0, 1'b1, 7'd55, 4'b0001, pk(7'd0, 7'd0, 7'd0, 7'd60), 4'b0000, 1'b0);
    send(1'b1, 1'b0, 7'd64, 4'b0011, pk(7'd0, 7'd0, 7'd64, 7'd60), 4'b0010, 1'b0);
    send(1'b1, 1'b0, 7'd60, 4'b0011, pk(7'd0, 7'd0, 7'd64, 7'd60), 4'b0001, 1'b0);

    // Strobe while busy is dropped.
    do_reset();
    expect_out(4'b0001, pk(7'd0, 7'd0, 7'd0, 7'd50), 4'b0001, 1'b0);
    @(negedge clk);
    note_on = 1'b1;
    note    = 7'd50;
    @(negedge clk);
    note_on = 1'b0;
    @(negedge clk);
    chk("busy_at_inject", {31'd0, busy}, 32'd1);
    note_on = 1'b1;
    note    = 7'd70;
    @(negedge clk);
    note_on = 1'b0;
    wait_idle("inject_len", 3);
    repeat (10) @(negedge clk);
    chk("dropped_idle", {31'd0, busy}, 32'd0);

    // Both strobes high: note_on wins.
    send(1'b1, 1'b1, 7'd61, 4'b0011, pk(7'd0, 7'd0, 7'd61, 7'd50), 4'b0010, 1'b0);

    // Reset in the middle of a scan.
    @(negedge clk);
    note_on = 1'b1;
    note    = 7'd90;
    @(negedge clk);
    note_on = 1'b0;
    @(negedge clk);
    chk("busy_in_scan", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_gate", {28'd0, voice_gate}, 32'd0);
    chk("midrst_note", {4'd0, voice_note}, 32'd0);
    chk("midrst_trig", {28'd0, voice_trig}, 32'd0);
    chk("midrst_steal", {31'd0, steal}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    send(1'b1, 1'b0, 7'd65, 4'b0001, pk(7'd0, 7'd0, 7'd0, 7'd65), 4'b0001, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
